// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage: PC, single-outstanding imem request, IF/ID register
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt/perf_stall_cnt outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] hold_q, hold_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic        load;
    logic [31:0] load_data;
    logic        req_fire;

    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_req_addr  = {pc_q[31:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = ifpc_q;
    assign if_id_pc_plus4 = ifpc4_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        ifpc_d    = ifpc_q;
        ifpc4_d   = ifpc4_q;
        load      = 1'b0;
        load_data = imem_resp_data;

        if (redirect_valid) begin
            // Redirect beats stall and any IF/ID load; an in-flight request must be dropped.
            pc_d    = redirect_pc & ~32'd3;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (stall) begin
                            hold_d  = imem_resp_data;
                            state_d = S_HOLD;
                        end else begin
                            load    = 1'b1;
                            state_d = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        load      = 1'b1;
                        load_data = hold_q;
                        state_d   = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        if (load) begin
            valid_d = 1'b1;
            instr_d = load_data;
            ifpc_d  = pc_q;
            ifpc4_d = pc_q + 32'd4;
            pc_d    = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            hold_q  <= 32'd0;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ifpc_q  <= RESET_PC;
            ifpc4_q <= RESET_PC + 32'd4;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (load && !redirect_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall && !redirect_valid) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

    // A response is only legal while a request is outstanding.
    a_resp_in_wait: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] stall_snap;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } load_t;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_req = 0;
    int n_load = 0;
    int credits = 0;
    int block = 0;
    int resp_delay = 0;
    int r0;
    int l0;
    bit pend = 1'b0;
    int pend_cnt = 0;
    logic [31:0] pend_addr = 32'd0;
    bit prev_valid = 1'b0;
    logic [31:0] prev_pc = 32'd0;
    logic [31:0] exp_req[$];
    load_t exp_load[$];
    int load_cyc[$];
    load_t mon_e;
    logic [31:0] mem_e;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push_load(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4);
        load_t e;
        e.pc = pc;
        e.instr = instr;
        e.pc4 = pc4;
        exp_load.push_back(e);
    endtask

    task automatic wait_req(input int target);
        int t = 0;
        while (n_req < target && t < 100) begin
            @(negedge clk); #3;
            t++;
        end
        check("req_arrived", {31'd0, n_req >= target}, 32'd1);
    endtask

    task automatic wait_loads(input int target);
        int t = 0;
        while (n_load < target && t < 100) begin
            @(negedge clk); #3;
            t++;
        end
        check("loads_arrived", {31'd0, n_load >= target}, 32'd1);
    endtask

    // Memory model: word at address a holds a>>2; accepted requests are checked against exp_req.
    always @(negedge clk) begin
        imem_resp_valid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            if (pend_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = {2'b00, pend_addr[31:2]};
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        imem_req_ready = (credits > 0) && (block == 0);
        if (block > 0) block--;
        #1;
        if (!rst && imem_req_valid && imem_req_ready) begin
            pend = 1'b1;
            pend_addr = imem_req_addr;
            pend_cnt = resp_delay;
            credits--;
            n_req++;
            if (exp_req.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_req: got addr %h required none", imem_req_addr);
            end else begin
                mem_e = exp_req.pop_front();
                check("req_addr", imem_req_addr, mem_e);
            end
        end
    end

    // IF/ID monitor: a new valid pc in the register is one load.
    always @(negedge clk) begin
        #2;
        if (!rst && if_id_valid && (!prev_valid || if_id_pc != prev_pc)) begin
            n_load++;
            load_cyc.push_back(cyc);
            if (exp_load.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_load: got pc %h required none", if_id_pc);
            end else begin
                mon_e = exp_load.pop_front();
                check("load_pc", if_id_pc, mon_e.pc);
                check("load_instr", if_id_instr, mon_e.instr);
                check("load_pc4", if_id_pc_plus4, mon_e.pc4);
            end
        end
        prev_valid = if_id_valid && !rst;
        prev_pc = if_id_pc;
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #3;
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_instr", if_id_instr, 32'h0000_0013);
        check("rst_pc", if_id_pc, 32'h0);
        check("rst_pc4", if_id_pc_plus4, 32'h4);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

        // Straight-line fetch, zero-wait memory
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        exp_req.push_back(32'h8);
        push_load(32'h0, 32'h0, 32'h4);
        push_load(32'h4, 32'h1, 32'h8);
        push_load(32'h8, 32'h2, 32'hC);
        rst = 1'b0;
        resp_delay = 0;
        credits = 3;
        wait_loads(3);
        if (load_cyc.size() >= 3) begin
            check("s1_gap01", load_cyc[1] - load_cyc[0], 32'd2);
            check("s1_gap12", load_cyc[2] - load_cyc[1], 32'd2);
        end

        // Stall 3 cycles while response for pc=12 arrives
        exp_req.push_back(32'hC);
        push_load(32'hC, 32'h3, 32'h10);
        r0 = n_req;
        credits = 1;
        wait_req(r0 + 1);
        @(negedge clk); #3;
`ifdef FETCH_PERF_CNT_EN
        stall_snap = perf_stall_cnt;
`endif
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk); #3;
            check("s2_hold_pc", if_id_pc, 32'h8);
            check("s2_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        stall = 1'b0;
        @(negedge clk); #3;
        check("s2_release_pc", if_id_pc, 32'hC);
`ifdef FETCH_PERF_CNT_EN
        check("s2_perf_stall", perf_stall_cnt - stall_snap, 32'd3);
`endif

        // Redirect while waiting; stale response is dropped
        exp_req.push_back(32'h10);
        exp_req.push_back(32'h100);
        push_load(32'h100, 32'h40, 32'h104);
        resp_delay = 1;
        r0 = n_req;
        l0 = n_load;
        credits = 2;
        wait_req(r0 + 1);
        @(negedge clk); #3;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk); #3;
        redirect_valid = 1'b0;
        check("s3_flush_valid", {31'd0, if_id_valid}, 32'd0);
        check("s3_flush_instr", if_id_instr, 32'h0000_0013);
        check("s3_flush_pc", if_id_pc, 32'hC);
        wait_loads(l0 + 1);

        // Stall and redirect together, misaligned target
        resp_delay = 0;
        @(negedge clk); #3;
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        @(negedge clk); #3;
        stall = 1'b0;
        redirect_valid = 1'b0;
        check("s4_flush_valid", {31'd0, if_id_valid}, 32'd0);
        check("s4_flush_instr", if_id_instr, 32'h0000_0013);
        check("s4_flush_pc", if_id_pc, 32'h100);
        check("s4_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("s4_req_addr", imem_req_addr, 32'h200);
        exp_req.push_back(32'h200);
        push_load(32'h200, 32'h80, 32'h204);
        l0 = n_load;
        credits = 1;
        wait_loads(l0 + 1);

        // PC wrap at top of address space
        @(negedge clk); #3;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk); #3;
        redirect_valid = 1'b0;
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0);
        push_load(32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0);
        push_load(32'h0, 32'h0, 32'h4);
        l0 = n_load;
        credits = 2;
        wait_loads(l0 + 2);

        // Ready held low 4 cycles in S_REQ
        exp_req.push_back(32'h4);
        push_load(32'h4, 32'h1, 32'h8);
        l0 = n_load;
        block = 4;
        credits = 1;
        repeat (4) begin
            @(negedge clk); #3;
            check("s6_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("s6_req_addr", imem_req_addr, 32'h4);
        end
        wait_loads(l0 + 1);

        repeat (4) @(negedge clk);
        #3;
        check("end_req_queue", exp_req.size(), 32'd0);
        check("end_load_queue", exp_load.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
